// File: rtl/alu_simple_pkg.sv
// Shared constants for the alu_simple execute-stage datapath: width, opcodes, shift modes.
package alu_simple_pkg;
  localparam int DATA_W = 32;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_PASSA = 4'b1000;
  localparam logic [3:0] OP_PASSB = 4'b1001;

  localparam logic [2:0] SH_NONE = 3'b000;
  localparam logic [2:0] SH_SLL  = 3'b001;
  localparam logic [2:0] SH_SRL  = 3'b010;
  localparam logic [2:0] SH_SRA  = 3'b011;
  localparam logic [2:0] SH_ROL  = 3'b100;
  localparam logic [2:0] SH_ROR  = 3'b101;
endpackage

// File: rtl/alu_simple_if.sv
// Operand/control/result bundle for alu_simple; Ovf exists only when ALU_SIMPLE_OVF_EN is defined.
interface alu_simple_if;
  import alu_simple_pkg::*;

  logic [DATA_W-1:0] In1;
  logic [DATA_W-1:0] In2;
  logic [3:0]        opcode;
  logic [2:0]        SR_Cont;
  logic [4:0]        SR_Bit;
  logic [DATA_W-1:0] Out;
`ifdef ALU_SIMPLE_OVF_EN
  logic              Ovf;
`endif

  modport master (
    output In1, In2, opcode, SR_Cont, SR_Bit,
`ifdef ALU_SIMPLE_OVF_EN
    input  Ovf,
`endif
    input  Out
  );

  modport slave (
    input  In1, In2, opcode, SR_Cont, SR_Bit,
`ifdef ALU_SIMPLE_OVF_EN
    output Ovf,
`endif
    output Out
  );
endinterface

// File: rtl/alu_shifter.sv
// Combinational post-op barrel shifter: logical/arithmetic shifts and rotates by 0-31.
module alu_shifter
  import alu_simple_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        mode_i,
  input  logic [4:0]        amt_i,
  output logic [DATA_W-1:0] data_o
);
  // Rotate complement uses a 6-bit amount so amt_i = 0 yields a shift by 32 (all zeros).
  logic [5:0] inv_amt;
  assign inv_amt = 6'd32 - {1'b0, amt_i};

  always_comb begin
    data_o = data_i;
    case (mode_i)
      SH_SLL:  data_o = data_i << amt_i;
      SH_SRL:  data_o = data_i >> amt_i;
      SH_SRA:  data_o = $unsigned($signed(data_i) >>> amt_i);
      SH_ROL:  data_o = (data_i << amt_i) | (data_i >> inv_amt);
      SH_ROR:  data_o = (data_i >> amt_i) | (data_i << inv_amt);
      default: data_o = data_i;
    endcase
  end
endmodule

// File: rtl/alu_simple.sv
// Single-cycle 32-bit ALU with post-op shifter and registered result.
// Optional signed-overflow flag enabled by defining ALU_SIMPLE_OVF_EN.
module alu_simple
  import alu_simple_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  alu_simple_if.slave   bus
);
  logic [DATA_W-1:0] op_res;
  logic [DATA_W-1:0] shift_res;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] out_d;

  always_comb begin
    op_res = '0;
    case (bus.opcode)
      OP_ADD:   op_res = bus.In1 + bus.In2;
      OP_SUB:   op_res = bus.In1 - bus.In2;
      OP_AND:   op_res = bus.In1 & bus.In2;
      OP_OR:    op_res = bus.In1 | bus.In2;
      OP_XOR:   op_res = bus.In1 ^ bus.In2;
      OP_NOR:   op_res = ~(bus.In1 | bus.In2);
      OP_SLT:   op_res = {{(DATA_W-1){1'b0}}, $signed(bus.In1) < $signed(bus.In2)};
      OP_SLTU:  op_res = {{(DATA_W-1){1'b0}}, bus.In1 < bus.In2};
      OP_PASSA: op_res = bus.In1;
      OP_PASSB: op_res = bus.In2;
      default:  op_res = '0;
    endcase
  end

  alu_shifter u_shifter (
    .data_i (op_res),
    .mode_i (bus.SR_Cont),
    .amt_i  (bus.SR_Bit),
    .data_o (shift_res)
  );

  assign out_d = shift_res;

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign bus.Out = out_q;

`ifdef ALU_SIMPLE_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Overflow is judged on the unshifted arithmetic result.
  always_comb begin
    ovf_d = 1'b0;
    case (bus.opcode)
      OP_ADD: ovf_d = (bus.In1[DATA_W-1] == bus.In2[DATA_W-1]) &&
                      (op_res[DATA_W-1] != bus.In1[DATA_W-1]);
      OP_SUB: ovf_d = (bus.In1[DATA_W-1] != bus.In2[DATA_W-1]) &&
                      (op_res[DATA_W-1] != bus.In1[DATA_W-1]);
      default: ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.Ovf = ovf_q;
`endif
endmodule

// File: tb/tb_alu_simple.sv
// Directed self-checking bench for alu_simple; checks Ovf too when ALU_SIMPLE_OVF_EN is defined.
module tb_alu_simple;
  import alu_simple_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  alu_simple_if bus ();

  alu_simple dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] sc, input logic [4:0] sb);
    @(negedge clk);
    bus.opcode  = op;
    bus.In1     = a;
    bus.In2     = b;
    bus.SR_Cont = sc;
    bus.SR_Bit  = sb;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [2:0] sc, input logic [4:0] sb,
                     input logic [31:0] exp_out, input logic exp_ovf);
    drive(op, a, b, sc, sb);
    check(tag, bus.Out, exp_out);
`ifdef ALU_SIMPLE_OVF_EN
    check({tag, ".ovf"}, {31'b0, bus.Ovf}, {31'b0, exp_ovf});
`else
    if (exp_ovf === 1'bx) $display("note %s: unknown ovf expectation", tag);
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;

    // Reset holds outputs at zero despite live inputs.
    drive(OP_ADD, 32'hFFFF_FFFF, 32'h1, SH_NONE, 5'd0);
    check("reset.out", bus.Out, 32'h0);
`ifdef ALU_SIMPLE_OVF_EN
    check("reset.ovf", {31'b0, bus.Ovf}, 32'h0);
`endif
    rst = 1'b0;
    run("rel.add",   OP_ADD, 32'hFFFF_FFFF, 32'h1, SH_NONE, 5'd0, 32'h0, 1'b0);

    run("add.negov", OP_ADD, 32'h8000_0001, 32'h8000_0001, SH_NONE, 5'd2, 32'h0000_0002, 1'b1);
    run("add.posov", OP_ADD, 32'h7FFF_FFFF, 32'h1, SH_NONE, 5'd0, 32'h8000_0000, 1'b1);
    run("add.5p7",   OP_ADD, 32'd5, 32'd7, SH_NONE, 5'd0, 32'd12, 1'b0);
    run("sub.3m5",   OP_SUB, 32'd3, 32'd5, SH_NONE, 5'd0, 32'hFFFF_FFFE, 1'b0);
    run("sub.ov",    OP_SUB, 32'h8000_0000, 32'h1, SH_NONE, 5'd0, 32'h7FFF_FFFF, 1'b1);
    run("slt",       OP_SLT, 32'hFFFF_FFFF, 32'h1, SH_NONE, 5'd0, 32'h1, 1'b0);
    run("sltu",      OP_SLTU, 32'hFFFF_FFFF, 32'h1, SH_NONE, 5'd0, 32'h0, 1'b0);
    run("passb",     OP_PASSB, 32'h0, 32'h1234_5678, SH_NONE, 5'd0, 32'h1234_5678, 1'b0);

    run("sh.sll",    OP_PASSA, 32'h8000_0001, 32'h0, SH_SLL, 5'd4, 32'h0000_0010, 1'b0);
    run("sh.srl",    OP_PASSA, 32'h8000_0001, 32'h0, SH_SRL, 5'd4, 32'h0800_0000, 1'b0);
    run("sh.sra",    OP_PASSA, 32'h8000_0001, 32'h0, SH_SRA, 5'd4, 32'hF800_0000, 1'b0);
    run("sh.rol",    OP_PASSA, 32'h8000_0001, 32'h0, SH_ROL, 5'd4, 32'h0000_0018, 1'b0);
    run("sh.ror",    OP_PASSA, 32'h8000_0001, 32'h0, SH_ROR, 5'd4, 32'h1800_0000, 1'b0);
    run("sh.sra0",   OP_PASSA, 32'h8000_0001, 32'h0, SH_SRA, 5'd0, 32'h8000_0001, 1'b0);
    run("sh.rol0",   OP_PASSA, 32'h8000_0001, 32'h0, SH_ROL, 5'd0, 32'h8000_0001, 1'b0);
    run("sh.ror31",  OP_PASSA, 32'h8000_0001, 32'h0, SH_ROR, 5'd31, 32'h0000_0003, 1'b0);
    run("sh.110",    OP_PASSA, 32'h8000_0001, 32'h0, 3'b110, 5'd4, 32'h8000_0001, 1'b0);

    run("log.and",   OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, SH_NONE, 5'd0, 32'hF000_F000, 1'b0);
    run("log.or",    OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, SH_NONE, 5'd0, 32'hFFF0_FFF0, 1'b0);
    run("log.xor",   OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, SH_NONE, 5'd0, 32'h0FF0_0FF0, 1'b0);
    run("log.nor",   OP_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, SH_NONE, 5'd0, 32'h000F_000F, 1'b0);
    run("op.1111",   4'b1111, 32'hF0F0_F0F0, 32'hFF00_FF00, SH_NONE, 5'd0, 32'h0, 1'b0);
    run("op.1010",   4'b1010, 32'hF0F0_F0F0, 32'hFF00_FF00, SH_SLL, 5'd3, 32'h0, 1'b0);

    // Mid-stream reset discards the pending result.
    rst = 1'b1;
    drive(OP_PASSA, 32'hDEAD_BEEF, 32'h0, SH_NONE, 5'd0);
    check("midrst.out", bus.Out, 32'h0);
    rst = 1'b0;
    run("after.rst", OP_PASSA, 32'hDEAD_BEEF, 32'h0, SH_NONE, 5'd0, 32'hDEAD_BEEF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
